// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//   Writes the ALU out register value back to either the register file or
//   the data memory. A start request latches the destination, the ALU value
//   is captured into a hold register, then a single-cycle write strobe and a
//   single-cycle completion pulse follow.
//
//   Sequence: IDLE -> LATCH -> WRITE -> DONE -> IDLE
//
// Configuration macro:
//   ALU_WB_BYPASS_EN : when defined, the LATCH state is removed. IDLE captures
//                      the ALU value together with the destination and goes
//                      straight to WRITE (one cycle less latency).
//
// Ports:
//   clock            in   system clock, rising-edge
//   reset            in   synchronous active-high reset
//   run              in   CPU run enable; low stalls the block
//   wb_start         in   writeback request (honoured only in IDLE)
//   wb_to_mem        in   destination select: 1 = data memory, 0 = reg file
//   wb_reg_sel[1:0]  in   destination register index
//   wb_mem_addr[4:0] in   destination data-memory address
//   alu_out_register[7:0] in  ALU out register value
//   reg_we / reg_waddr[1:0] / reg_wdata[7:0]  out  register-file write port
//   mem_we / mem_waddr[4:0] / mem_wdata[7:0]  out  data-memory write port
//   wb_busy          out  high in every state except IDLE
//   wb_done          out  one-cycle completion pulse
//   wb_overrun       out  sticky: start requested while busy
// ---------------------------------------------------------------------------
module alu_writeback (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       wb_start,
    input  logic       wb_to_mem,
    input  logic [1:0] wb_reg_sel,
    input  logic [4:0] wb_mem_addr,
    input  logic [7:0] alu_out_register,
    output logic       reg_we,
    output logic [1:0] reg_waddr,
    output logic [7:0] reg_wdata,
    output logic       mem_we,
    output logic [4:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       wb_busy,
    output logic       wb_done,
    output logic       wb_overrun
);

`ifdef ALU_WB_BYPASS_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`endif

    state_t     r_state;
    logic       r_to_mem;
    logic [1:0] r_reg_sel;
    logic [4:0] r_mem_addr;
    logic [7:0] r_hold;
    logic       r_reg_we;
    logic       r_mem_we;
    logic       r_busy;
    logic       r_done;
    logic       r_overrun;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_to_mem   <= 1'b0;
            r_reg_sel  <= 2'd0;
            r_mem_addr <= 5'd0;
            r_hold     <= 8'd0;
            r_reg_we   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (run) begin
            // A request arriving while busy is dropped but remembered.
            if (wb_start && r_busy) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (wb_start) begin
                        r_to_mem   <= wb_to_mem;
                        r_reg_sel  <= wb_reg_sel;
                        r_mem_addr <= wb_mem_addr;
                        r_busy     <= 1'b1;
`ifdef ALU_WB_BYPASS_EN
                        r_hold     <= alu_out_register;
                        r_state    <= ST_WRITE;
`else
                        r_state    <= ST_LATCH;
`endif
                    end
                end
`ifndef ALU_WB_BYPASS_EN
                ST_LATCH: begin
                    r_hold  <= alu_out_register;
                    r_state <= ST_WRITE;
                end
`endif
                ST_WRITE: begin
                    // Strobe becomes visible in the DONE cycle and is held
                    // there until a run-qualified cycle lets it through.
                    r_reg_we <= ~r_to_mem;
                    r_mem_we <= r_to_mem;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_reg_we <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pulses are masked while stalled; the underlying registers hold, so the
    // pulse appears exactly once when run returns.
    assign reg_we     = r_reg_we & run;
    assign mem_we     = r_mem_we & run;
    assign wb_done    = r_done & run;
    assign reg_waddr  = r_reg_sel;
    assign mem_waddr  = r_mem_addr;
    assign reg_wdata  = r_hold;
    assign mem_wdata  = r_hold;
    assign wb_busy    = r_busy;
    assign wb_overrun = r_overrun;

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback
//   Self-checking bench for alu_writeback: a table of writeback transactions
//   with hand-computed results, plus directed sequences for stall, overrun,
//   start-during-DONE and reset-mid-write. Honours ALU_WB_BYPASS_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_writeback;

    logic       clock;
    logic       reset;
    logic       run;
    logic       wb_start;
    logic       wb_to_mem;
    logic [1:0] wb_reg_sel;
    logic [4:0] wb_mem_addr;
    logic [7:0] alu_out_register;
    logic       reg_we;
    logic [1:0] reg_waddr;
    logic [7:0] reg_wdata;
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       wb_busy;
    logic       wb_done;
    logic       wb_overrun;

    alu_writeback dut (
        .clock            (clock),
        .reset            (reset),
        .run              (run),
        .wb_start         (wb_start),
        .wb_to_mem        (wb_to_mem),
        .wb_reg_sel       (wb_reg_sel),
        .wb_mem_addr      (wb_mem_addr),
        .alu_out_register (alu_out_register),
        .reg_we           (reg_we),
        .reg_waddr        (reg_waddr),
        .reg_wdata        (reg_wdata),
        .mem_we           (mem_we),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata),
        .wb_busy          (wb_busy),
        .wb_done          (wb_done),
        .wb_overrun       (wb_overrun)
    );

`ifdef ALU_WB_BYPASS_EN
    localparam int STROBE_AT = 1;
    localparam int DONE_AT   = 2;
`else
    localparam int STROBE_AT = 2;
    localparam int DONE_AT   = 3;
`endif

    typedef struct {
        logic       to_mem;
        logic [1:0] reg_sel;
        logic [4:0] mem_addr;
        logic [7:0] alu;
        int         exp_reg_cnt;
        int         exp_mem_cnt;
        int         exp_addr;
        int         exp_data;
    } vec_t;

    vec_t vecs [6];
    int   total = 0;
    int   bad   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; sample/drive well away from it.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_wb(input vec_t v, input int idx);
        int n_reg, n_mem, n_done, strobe_at, done_at;
        logic [31:0] addr, rdata, mdata;
        n_reg = 0; n_mem = 0; n_done = 0; strobe_at = -1; done_at = -1;
        addr = '0; rdata = '0; mdata = '0;
        wb_to_mem        = v.to_mem;
        wb_reg_sel       = v.reg_sel;
        wb_mem_addr      = v.mem_addr;
        alu_out_register = v.alu;
        wb_start         = 1'b1;
        tick();                                  // edge k
        wb_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin
                check($sformatf("v%0d busy", idx), wb_busy, 1);
                alu_out_register = 8'hFF;        // late change must not leak
            end
            if (reg_we || mem_we) begin
                if (strobe_at < 0) begin
                    strobe_at = i;
                    addr  = reg_we ? 32'(reg_waddr) : 32'(mem_waddr);
                    rdata = 32'(reg_wdata);
                    mdata = 32'(mem_wdata);
                end
            end
            if (reg_we) n_reg++;
            if (mem_we) n_mem++;
            if (wb_done) begin
                n_done++;
                if (done_at < 0) done_at = i;
            end
        end
        check($sformatf("v%0d reg_we count", idx), n_reg, v.exp_reg_cnt);
        check($sformatf("v%0d mem_we count", idx), n_mem, v.exp_mem_cnt);
        check($sformatf("v%0d strobe cycle", idx), strobe_at, STROBE_AT);
        check($sformatf("v%0d waddr", idx), addr, v.exp_addr);
        check($sformatf("v%0d reg_wdata", idx), rdata, v.exp_data);
        check($sformatf("v%0d mem_wdata", idx), mdata, v.exp_data);
        check($sformatf("v%0d done count", idx), n_done, 1);
        check($sformatf("v%0d done cycle", idx), done_at, DONE_AT);
        check($sformatf("v%0d busy end", idx), wb_busy, 0);
    endtask

    initial begin
        int n_str, n_done;

        //              to_mem sel    addr   alu    reg mem addr   data
        vecs[0] = '{1'b0, 2'd2, 5'h07, 8'h5A, 1, 0, 2,     'h5A};
        vecs[1] = '{1'b1, 2'd3, 5'h1F, 8'hC3, 0, 1, 'h1F, 'hC3};
        vecs[2] = '{1'b0, 2'd0, 5'h1F, 8'h81, 1, 0, 0,     'h81};
        vecs[3] = '{1'b1, 2'd1, 5'h00, 8'h00, 0, 1, 0,     'h00};
        vecs[4] = '{1'b0, 2'd3, 5'h10, 8'h3C, 1, 0, 3,     'h3C};
        vecs[5] = '{1'b1, 2'd0, 5'h15, 8'h7E, 0, 1, 'h15, 'h7E};

        reset = 1'b1; run = 1'b1; wb_start = 1'b0; wb_to_mem = 1'b0;
        wb_reg_sel = 2'd0; wb_mem_addr = 5'd0; alu_out_register = 8'd0;
        tick();
        tick();
        check("reset reg_we", reg_we, 0);
        check("reset mem_we", mem_we, 0);
        check("reset busy", wb_busy, 0);
        check("reset done", wb_done, 0);
        check("reset overrun", wb_overrun, 0);
        check("reset wdata", reg_wdata, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_wb(vecs[i], i);
        end
        check("no overrun after table", wb_overrun, 0);

        // Stall in WRITE: no strobe while run=0, exactly one afterwards.
        wb_to_mem = 1'b1; wb_mem_addr = 5'h0A; alu_out_register = 8'hA5;
        wb_start = 1'b1;
        tick();
        wb_start = 1'b0;
`ifndef ALU_WB_BYPASS_EN
        tick();
`endif
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d strobe", i), reg_we | mem_we, 0);
            check($sformatf("stall%0d busy", i), wb_busy, 1);
        end
        run = 1'b1;
        n_str = 0; n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_we) begin
                n_str++;
                check("stall data", mem_wdata, 8'hA5);
            end
            if (reg_we) n_str = n_str + 10;
            if (wb_done) n_done++;
        end
        check("stall strobe count", n_str, 1);
        check("stall done count", n_done, 1);

        // Overrun: second start during the busy period.
        wb_to_mem = 1'b0; wb_reg_sel = 2'd1; alu_out_register = 8'h33;
        wb_start = 1'b1;
        tick();
        n_str = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) wb_start = 1'b0;
            if (reg_we || mem_we) n_str++;
        end
        check("overrun strobe count", n_str, 1);
        check("overrun flag set", wb_overrun, 1);
        do_wb(vecs[0], 10);
        check("overrun sticky", wb_overrun, 1);
        do_reset();
        check("overrun cleared", wb_overrun, 0);

        // Start in the DONE cycle must not be accepted.
        wb_to_mem = 1'b0; wb_reg_sel = 2'd2; alu_out_register = 8'h44;
        wb_start = 1'b1;
        tick();
        wb_start = 1'b0;
        n_str = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (reg_we || mem_we) n_str++;
            wb_start = (i == DONE_AT - 1) ? 1'b1 : 1'b0;
        end
        check("done-start strobe count", n_str, 1);
        check("done-start busy", wb_busy, 0);
        check("done-start overrun", wb_overrun, 1);
        do_reset();

        // Reset mid-WRITE aborts with everything cleared.
        wb_to_mem = 1'b1; wb_mem_addr = 5'h1F; alu_out_register = 8'hC3;
        wb_start = 1'b1;
        tick();
        wb_start = 1'b0;
`ifndef ALU_WB_BYPASS_EN
        tick();
`endif
        reset = 1'b1;
        tick();
        check("rstw reg_we", reg_we, 0);
        check("rstw mem_we", mem_we, 0);
        check("rstw busy", wb_busy, 0);
        check("rstw mem_wdata", mem_wdata, 0);
        check("rstw reg_wdata", reg_wdata, 0);
        check("rstw mem_waddr", mem_waddr, 0);
        check("rstw reg_waddr", reg_waddr, 0);
        reset = 1'b0;
        n_str = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (reg_we || mem_we || wb_done) n_str++;
        end
        check("rstw no late activity", n_str, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
